// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. It contains the forwarding muxes, the ALU, the
// destination select and, when MULDIV_EN is defined, the iterative mult/div unit
// with the HI/LO registers.
// Ports:
//   i_clock/i_reset  : clock, synchronous active-high reset
//   i_regA/i_regB, i_extendido, i_opcode, i_rt/i_rd, i_ex, i_mem, i_wb : from ID/EX
//   i_fwd_a/i_fwd_b, i_exmem_result/i_memwb_result : forwarding selects and data
//   o_alu_result, o_store_data, o_write_reg, o_zero, o_mem, o_wb : to EX/MEM
//   o_stall : holds PC, IF/ID and ID/EX while a mult/div is running
//   o_hi/o_lo : debug view of HI/LO (tied 0 without MULDIV_EN)
module ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZEOP     = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_regA,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic [DATA_WIDTH-1:0] i_extendido,
    input  logic [SIZEOP-1:0]     i_opcode,
    input  logic [4:0]            i_rt,
    input  logic [4:0]            i_rd,
    input  logic [3:0]            i_ex,
    input  logic [2:0]            i_mem,
    input  logic [1:0]            i_wb,
    input  logic [1:0]            i_fwd_a,
    input  logic [1:0]            i_fwd_b,
    input  logic [DATA_WIDTH-1:0] i_exmem_result,
    input  logic [DATA_WIDTH-1:0] i_memwb_result,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_store_data,
    output logic [4:0]            o_write_reg,
    output logic                  o_zero,
    output logic [2:0]            o_mem,
    output logic [1:0]            o_wb,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W = DATA_WIDTH;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [SIZEOP-1:0] OP_SLTI  = SIZEOP'(6'h0A);
    localparam logic [SIZEOP-1:0] OP_SLTIU = SIZEOP'(6'h0B);
    localparam logic [SIZEOP-1:0] OP_ANDI  = SIZEOP'(6'h0C);
    localparam logic [SIZEOP-1:0] OP_ORI   = SIZEOP'(6'h0D);
    localparam logic [SIZEOP-1:0] OP_XORI  = SIZEOP'(6'h0E);
    localparam logic [SIZEOP-1:0] OP_LUI   = SIZEOP'(6'h0F);

    logic       reg_dst;
    logic [1:0] aluop;
    logic       alusrc;
    logic [5:0] funct;
    logic [4:0] shamt;

    assign reg_dst = i_ex[3];
    assign aluop   = i_ex[2:1];
    assign alusrc  = i_ex[0];
    assign funct   = i_extendido[5:0];
    assign shamt   = i_extendido[10:6];

    logic [W-1:0] op_a;
    logic [W-1:0] fwd_b;
    logic [W-1:0] op_b;

    always_comb begin
        case (i_fwd_a)
            2'b01:   op_a = i_exmem_result;
            2'b10:   op_a = i_memwb_result;
            default: op_a = i_regA;
        endcase
        case (i_fwd_b)
            2'b01:   fwd_b = i_exmem_result;
            2'b10:   fwd_b = i_memwb_result;
            default: fwd_b = i_regB;
        endcase
    end

    assign op_b         = alusrc ? i_extendido : fwd_b;
    assign o_store_data = fwd_b;
    assign o_write_reg  = reg_dst ? i_rd : i_rt;

    // HI/LO as seen by MFHI/MFLO; constant zero without the mult/div unit.
    logic [W-1:0] hi_val;
    logic [W-1:0] lo_val;

    logic [W-1:0] imm_zx;
    logic [W-1:0] lt_s;
    logic [W-1:0] lt_u;

    assign imm_zx = {{(W-16){1'b0}}, op_b[15:0]};
    assign lt_s   = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
    assign lt_u   = {{(W-1){1'b0}}, op_a < op_b};

    logic [W-1:0] r_res;
    logic [W-1:0] i_res;
    logic [W-1:0] alu_res;

    always_comb begin
        r_res = '0;
        case (funct)
            F_ADD, F_ADDU: r_res = op_a + op_b;
            F_SUB, F_SUBU: r_res = op_a - op_b;
            F_AND:         r_res = op_a & op_b;
            F_OR:          r_res = op_a | op_b;
            F_XOR:         r_res = op_a ^ op_b;
            F_NOR:         r_res = ~(op_a | op_b);
            F_SLT:         r_res = lt_s;
            F_SLTU:        r_res = lt_u;
            F_SLL:         r_res = op_b << shamt;
            F_SRL:         r_res = op_b >> shamt;
            F_SRA:         r_res = $signed(op_b) >>> shamt;
            F_SLLV:        r_res = op_b << op_a[4:0];
            F_SRLV:        r_res = op_b >> op_a[4:0];
            F_SRAV:        r_res = $signed(op_b) >>> op_a[4:0];
            F_MFHI:        r_res = hi_val;
            F_MFLO:        r_res = lo_val;
            default:       r_res = '0;
        endcase
    end

    always_comb begin
        i_res = '0;
        case (i_opcode)
            OP_ANDI:  i_res = op_a & imm_zx;
            OP_ORI:   i_res = op_a | imm_zx;
            OP_XORI:  i_res = op_a ^ imm_zx;
            OP_SLTI:  i_res = lt_s;
            OP_SLTIU: i_res = lt_u;
            OP_LUI:   i_res = imm_zx << 16;
            default:  i_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (aluop)
            2'b00:   alu_res = op_a + op_b;
            2'b01:   alu_res = op_a - op_b;
            2'b10:   alu_res = r_res;
            default: alu_res = i_res;
        endcase
    end

    assign o_alu_result = alu_res;
    assign o_zero       = (alu_res == '0);

`ifdef MULDIV_EN
    localparam int CW = $clog2(W + 1);

    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MTLO = 6'h13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // acc_hi: partial product high half / running remainder.
    // acc_lo: multiplier shifting out / dividend shifting into quotient.
    logic [W-1:0]  acc_hi_q, acc_hi_d;
    logic [W-1:0]  acc_lo_q, acc_lo_d;
    logic [W-1:0]  dvsr_q, dvsr_d;
    logic          div_q, div_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;

    logic           mdstart;
    logic           md_signed;
    logic           neg_a;
    logic           neg_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     msum;
    logic [W:0]     rshift;
    logic [W:0]     rdiff;
    logic [2*W-1:0] prod;

    // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B.
    assign mdstart   = (aluop == 2'b10) && (funct[5:2] == 4'b0110);
    assign md_signed = ~funct[0];
    assign neg_a     = md_signed & op_a[W-1];
    assign neg_b     = md_signed & op_b[W-1];
    assign mag_a     = neg_a ? -op_a : op_a;
    assign mag_b     = neg_b ? -op_b : op_b;

    assign msum   = {1'b0, acc_hi_q}
                  + (acc_lo_q[0] ? {1'b0, dvsr_q} : '0);
    assign rshift = {acc_hi_q, acc_lo_q[W-1]};
    assign rdiff  = rshift - {1'b0, dvsr_q};
    assign prod   = {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        dvsr_d   = dvsr_q;
        div_d    = div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mdstart) begin
                    state_d  = S_BUSY;
                    cnt_d    = CW'(W);
                    acc_hi_d = '0;
                    div_d    = funct[1];
                    dz_d     = funct[1] && (op_b == '0);
                    if (funct[1]) begin
                        acc_lo_d = mag_a;
                        dvsr_d   = mag_b;
                        // Divide by zero keeps LO all ones, so no negate.
                        qneg_d   = (neg_a ^ neg_b) && (op_b != '0);
                        rneg_d   = neg_a;
                    end else begin
                        acc_lo_d = mag_b;
                        dvsr_d   = mag_a;
                        qneg_d   = neg_a ^ neg_b;
                        rneg_d   = 1'b0;
                    end
                end else if (aluop == 2'b10 && funct == F_MTHI) begin
                    hi_d = op_a;
                end else if (aluop == 2'b10 && funct == F_MTLO) begin
                    lo_d = op_a;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
                if (div_q) begin
                    // Zero divisor always "fits", giving all-ones quotient
                    // and the dividend magnitude as remainder.
                    if (dz_q || !rdiff[W]) begin
                        acc_hi_d = rdiff[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rshift[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = msum[W:1];
                    acc_lo_d = {msum[0], acc_lo_q[W-1:1]};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (div_q) begin
                    lo_d = qneg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = qneg_q ? -prod : prod;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            dvsr_q   <= '0;
            div_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            dvsr_q   <= dvsr_d;
            div_q    <= div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_val  = hi_q;
    assign lo_val  = lo_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    // DONE drops the stall so the held instruction retires once.
    assign o_stall = (state_q == S_IDLE && mdstart)
                   || (state_q == S_BUSY);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = i_clock ^ i_reset;

    assign hi_val  = '0;
    assign lo_val  = '0;
    assign o_hi    = '0;
    assign o_lo    = '0;
    assign o_stall = 1'b0;
`endif

    assign o_mem = o_stall ? 3'b000 : i_mem;
    assign o_wb  = o_stall ? 2'b00 : i_wb;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed plus randomized checks of ex_stage against a
// behavioural model; mult/div checks run when MULDIV_EN is defined.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] regA, regB, ext, exmem, memwb;
    logic [5:0]  opcode;
    logic [4:0]  rt, rd;
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb, fwd_a, fwd_b;
    logic [31:0] alu_result, store_data, hi, lo;
    logic [4:0]  write_reg;
    logic        zero, stall;
    logic [2:0]  mem_o;
    logic [1:0]  wb_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    ex_stage dut (
        .i_clock(clk), .i_reset(rst),
        .i_regA(regA), .i_regB(regB), .i_extendido(ext),
        .i_opcode(opcode), .i_rt(rt), .i_rd(rd),
        .i_ex(ex), .i_mem(mem), .i_wb(wb),
        .i_fwd_a(fwd_a), .i_fwd_b(fwd_b),
        .i_exmem_result(exmem), .i_memwb_result(memwb),
        .o_alu_result(alu_result), .o_store_data(store_data),
        .o_write_reg(write_reg), .o_zero(zero),
        .o_mem(mem_o), .o_wb(wb_o), .o_stall(stall),
        .o_hi(hi), .o_lo(lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result of one ALU instruction given already-forwarded operands.
    function automatic logic [31:0] ref_alu(
        input logic [1:0] aop, input logic [5:0] fn, input logic [4:0] sh,
        input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] h, input logic [31:0] l);
        logic [31:0] amt;
        amt = a % 32;
        if (aop == 2'd0) return a + b;
        if (aop == 2'd1) return a - b;
        if (aop == 2'd2) begin
            case (fn)
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: return (a < b) ? 32'd1 : 32'd0;
                6'h00: return b << sh;
                6'h02: return b >> sh;
                6'h03: return $signed(b) >>> sh;
                6'h04: return b << amt;
                6'h06: return b >> amt;
                6'h07: return $signed(b) >>> amt;
                6'h10: return h;
                6'h12: return l;
                default: return 32'd0;
            endcase
        end
        case (opc)
            6'h0C: return a & (b % 65536);
            6'h0D: return a | (b % 65536);
            6'h0E: return a ^ (b % 65536);
            6'h0A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h0B: return (a < b) ? 32'd1 : 32'd0;
            6'h0F: return (b % 65536) * 65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] h,
                          output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'h0;
        l = 32'h0;
        if (fn == 6'h18) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (fn == 6'h19) begin
            p = {32'h0, a} * {32'h0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'h0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (fn == 6'h1A) begin
            q = sa / sb;
            r = sa % sb;
            l = 32'(q);
            h = 32'(r);
        end else begin
            l = a / b;
            h = a % b;
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic [5:0] opc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] x);
        ex = e; opcode = opc; regA = a; regB = b; ext = x;
        fwd_a = 2'b00; fwd_b = 2'b00;
        exmem = 32'h0; memwb = 32'h0;
        mem = 3'b101; wb = 2'b10; rt = 5'd3; rd = 5'd7;
    endtask

`ifdef MULDIV_EN
    task automatic run_md(input string tag, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        int bad;
        logic [31:0] eh, el;
        md_ref(fn, a, b, eh, el);
        @(negedge clk);
        drive(4'b1100, 6'h00, a, b, {26'h0, fn});
        mem = 3'b111; wb = 2'b11;
        n = 0; bad = 0;
        #1;
        while (stall && n < 100) begin
            if (mem_o !== 3'b000 || wb_o !== 2'b00) bad++;
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " stall cycles"}, n, 33);
        chk({tag, " bubbles"}, bad, 0);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h20);
        #1;
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask
`endif

    logic [5:0] fns [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                             6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                             6'h3F, 6'h05};
    logic [5:0] opcs [8] = '{6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F,
                             6'h08, 6'h23};

    initial begin
        logic [1:0]  aop, fa, fb;
        logic        src, rdsel;
        logic [5:0]  fn, opc;
        logic [4:0]  sh;
        logic [31:0] r, a, b, oa, ob, exp;

        rst = 1'b1;
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h20);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h7FFF_FFFF, 32'h1, 32'h20);
        #1;
        chk("add result", alu_result, 32'h8000_0000);
        chk("add zero", 32'(zero), 32'd0);
        chk("add write_reg", 32'(write_reg), 32'd7);
        chk("add mem", 32'(mem_o), 32'd5);
        chk("add wb", 32'(wb_o), 32'd2);

        @(negedge clk);
        drive(4'b0010, 6'h00, 32'd5, 32'd5, 32'h0);
        #1;
        chk("sub result", alu_result, 32'h0);
        chk("sub zero", 32'(zero), 32'd1);
        chk("sub write_reg", 32'(write_reg), 32'd3);

        @(negedge clk);
        drive(4'b0001, 6'h08, 32'h99, 32'h55, 32'h4);
        fwd_a = 2'b01; exmem = 32'h10;
        fwd_b = 2'b10; memwb = 32'hCAFE_0001;
        #1;
        chk("fwd addi", alu_result, 32'h14);
        chk("fwd store", store_data, 32'hCAFE_0001);

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h8000_0000, {21'h0, 5'd4, 6'h03});
        #1;
        chk("sra", alu_result, 32'hF800_0000);

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h1, 32'hFFFF_FFFF, 32'h2B);
        #1;
        chk("sltu", alu_result, 32'h1);

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h1, 32'hFFFF_FFFF, 32'h2A);
        #1;
        chk("slt", alu_result, 32'h0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            aop   = 2'($urandom_range(0, 3));
            src   = 1'($urandom_range(0, 1));
            rdsel = 1'($urandom_range(0, 1));
            fn    = fns[$urandom_range(0, 19)];
            opc   = opcs[$urandom_range(0, 7)];
            sh    = 5'($urandom_range(0, 31));
            r     = $urandom();
            a     = $urandom();
            b     = ($urandom_range(0, 3) == 0) ? a : $urandom();
            fa    = 2'($urandom_range(0, 3));
            fb    = 2'($urandom_range(0, 3));
            drive({rdsel, aop, src}, opc, a, b, {r[31:11], sh, fn});
            fwd_a = fa; fwd_b = fb;
            exmem = $urandom(); memwb = $urandom();
            mem = 3'($urandom_range(0, 7)); wb = 2'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
            oa = (fa == 2'd1) ? exmem : (fa == 2'd2) ? memwb : a;
            ob = (fb == 2'd1) ? exmem : (fb == 2'd2) ? memwb : b;
            exp = ref_alu(aop, fn, sh, opc, oa, src ? ext : ob, m_hi, m_lo);
            #1;
            chk("rand result", alu_result, exp);
            chk("rand zero", 32'(zero), (exp == 32'h0) ? 32'd1 : 32'd0);
            chk("rand store", store_data, ob);
            chk("rand write_reg", 32'(write_reg), 32'(rdsel ? rd : rt));
            chk("rand mem", 32'(mem_o), 32'(mem));
            chk("rand wb", 32'(wb_o), 32'(wb));
            chk("rand stall", 32'(stall), 32'd0);
        end

`ifdef MULDIV_EN
        run_md("mult", 6'h18, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h12);
        #1;
        chk("mflo after mult", alu_result, 32'hFFFF_FFEB);
        chk("mult hi const", m_hi, 32'hFFFF_FFFF);
        run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        chk("div lo const", m_lo, 32'hFFFF_FFFD);
        chk("div hi const", m_hi, 32'hFFFF_FFFF);
        run_md("divu0", 6'h1B, 32'd9, 32'd0);
        chk("divu0 lo const", m_lo, 32'hFFFF_FFFF);
        run_md("div0 neg", 6'h1A, 32'hFFFF_FF00, 32'd0);
        for (int i = 0; i < 8; i++) begin
            fn = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom() >> $urandom_range(0, 31);
            run_md("rand md", fn, a, b);
        end

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h1234_5678, 32'h0, 32'h11);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h9ABC_DEF0, 32'h0, 32'h13);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h10);
        #1;
        chk("mthi->mfhi", alu_result, 32'h1234_5678);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h12);
        #1;
        chk("mtlo->mflo", alu_result, 32'h9ABC_DEF0);

        @(negedge clk);
        drive(4'b1100, 6'h00, 32'd5, 32'd6, 32'h18);
        repeat (11) @(negedge clk);
        #1;
        chk("busy stall", 32'(stall), 32'd1);
        rst = 1'b1;
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy stall", 32'(stall), 32'd0);
        chk("reset busy hi", hi, 32'h0);
        chk("reset busy lo", lo, 32'h0);
`else
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'hFFFF_FFFD, 32'd7, 32'h18);
        #1;
        chk("nomd mult stall", 32'(stall), 32'd0);
        chk("nomd mult result", alu_result, 32'h0);
        chk("nomd mult wb", 32'(wb_o), 32'd2);
        repeat (40) @(negedge clk);
        #1;
        chk("nomd hi", hi, 32'h0);
        chk("nomd lo", lo, 32'h0);
        drive(4'b1100, 6'h00, 32'h55, 32'h0, 32'h11);
        #1;
        chk("nomd mthi result", alu_result, 32'h0);
        @(negedge clk);
        drive(4'b1100, 6'h00, 32'h0, 32'h0, 32'h10);
        #1;
        chk("nomd mfhi", alu_result, 32'h0);
        chk("nomd hi after mthi", hi, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
